// File: rtl/mix_round_sequencer.sv
// Sequencer for the 8-lane 32-bit mixing round: one in-place lane update per clock,
// walking a fixed phase schedule for a host-programmed number of rounds.
module mix_round_sequencer #(
    parameter int FB_REPS  = 12,
    parameter int MUL_REPS = 6,
    parameter int RND_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [RND_W-1:0] rounds_i,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_sel_i,
    input  logic [31:0]      wr_data_i,
    input  logic [2:0]       rd_sel_i,
    output logic [31:0]      rd_data_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {IDLE, RUN} state_e;
    typedef enum logic [2:0] {
        PH_ADD, PH_CHAIN, PH_CROSS, PH_XSH, PH_SHMIX, PH_FB, PH_MULA, PH_MULB
    } phase_e;

    localparam logic [15:0] FB_LAST  = 16'((FB_REPS  > 0) ? FB_REPS  - 1 : 0);
    localparam logic [15:0] MUL_LAST = 16'((MUL_REPS > 0) ? MUL_REPS - 1 : 0);

    state_e           state_q;
    phase_e           phase_q;
    logic [15:0]      pass_q;
    logic [2:0]       idx_q;
    logic [RND_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      lane_q [8];

    function automatic logic [31:0] ma(input logic [2:0] i);
        case (i)
            3'd0: ma = 32'd2;   3'd1: ma = 32'd3;   3'd2: ma = 32'd5;   3'd3: ma = 32'd7;
            3'd4: ma = 32'd11;  3'd5: ma = 32'd13;  3'd6: ma = 32'd17;  default: ma = 32'd19;
        endcase
    endfunction

    function automatic logic [31:0] ca(input logic [2:0] i);
        case (i)
            3'd0: ca = 32'd3;   3'd1: ca = 32'd5;   3'd2: ca = 32'd7;   3'd3: ca = 32'd11;
            3'd4: ca = 32'd13;  3'd5: ca = 32'd17;  3'd6: ca = 32'd19;  default: ca = 32'd23;
        endcase
    endfunction

    function automatic logic [31:0] mb(input logic [2:0] i);
        case (i)
            3'd0: mb = 32'd2;   3'd1: mb = 32'd3;   3'd2: mb = 32'd3;   3'd3: mb = 32'd3;
            3'd4: mb = 32'd5;   3'd5: mb = 32'd13;  3'd6: mb = 32'd35;  default: mb = 32'd87;
        endcase
    endfunction

    function automatic logic [31:0] cb(input logic [2:0] i);
        case (i)
            3'd0: cb = 32'd0;   3'd1: cb = 32'd1;   3'd2: cb = 32'd8;   3'd3: cb = 32'd27;
            3'd4: cb = 32'd64;  3'd5: cb = 32'd125; 3'd6: cb = 32'd216; default: cb = 32'd343;
        endcase
    endfunction

    // Neighbour indices wrap naturally in 3 bits; reads see lanes already updated this pass.
    logic [2:0]  i1, i2, i3, i4, i5, i6, i7;
    logic [31:0] cur, upd;

    always_comb begin
        i1  = idx_q + 3'd1;
        i2  = idx_q + 3'd2;
        i3  = idx_q + 3'd3;
        i4  = idx_q + 3'd4;
        i5  = idx_q + 3'd5;
        i6  = idx_q + 3'd6;
        i7  = idx_q + 3'd7;
        cur = lane_q[idx_q];
        upd = cur;
        case (phase_q)
            PH_ADD:   upd = cur + {29'd0, idx_q};
            PH_CHAIN: upd = cur + lane_q[i7];
            PH_CROSS: upd = cur + lane_q[i1] - lane_q[i5];
            PH_XSH:   upd = cur ^ (lane_q[i3] << 16);
            PH_SHMIX: upd = cur - (lane_q[i2] >> 17) + (lane_q[i4] >> 12);
            PH_FB:    upd = cur + lane_q[i7] - lane_q[i6];
            PH_MULA:  upd = cur * ma(idx_q) + ca(idx_q);
            PH_MULB:  upd = cur * mb(idx_q) + cb(idx_q);
            default:  upd = cur;
        endcase
    end

    // Phase/pass advance taken when the lane index wraps; zero-repeat phases are skipped.
    phase_e      nxt_phase;
    logic [15:0] nxt_pass;
    logic        round_end;

    always_comb begin
        nxt_phase = phase_q;
        nxt_pass  = pass_q;
        round_end = 1'b0;
        case (phase_q)
            PH_SHMIX: begin
                if (FB_REPS > 0)       nxt_phase = PH_FB;
                else if (MUL_REPS > 0) nxt_phase = PH_MULA;
                else                   round_end = 1'b1;
            end
            PH_FB: begin
                if (pass_q == FB_LAST) begin
                    nxt_pass = 16'd0;
                    if (MUL_REPS > 0) nxt_phase = PH_MULA;
                    else              round_end = 1'b1;
                end else begin
                    nxt_pass = pass_q + 16'd1;
                end
            end
            PH_MULA: nxt_phase = PH_MULB;
            PH_MULB: begin
                if (pass_q == MUL_LAST) begin
                    nxt_pass  = 16'd0;
                    round_end = 1'b1;
                end else begin
                    nxt_pass  = pass_q + 16'd1;
                    nxt_phase = PH_MULA;
                end
            end
            default: nxt_phase = phase_e'(phase_q + 3'd1);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= PH_ADD;
            pass_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 8; k++) lane_q[k] <= 32'(k);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_en_i) lane_q[wr_sel_i] <= wr_data_i;
                    if (start_i) begin
                        rem_q   <= rounds_i;
                        phase_q <= PH_ADD;
                        pass_q  <= '0;
                        idx_q   <= '0;
                        if (rounds_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    lane_q[idx_q] <= upd;
                    idx_q         <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        phase_q <= nxt_phase;
                        pass_q  <= nxt_pass;
                        if (round_end) begin
                            phase_q <= PH_ADD;
                            // Down-counting remaining rounds avoids any wrap at the max count.
                            if (rem_q == RND_W'(1)) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                rem_q   <= '0;
                            end else begin
                                rem_q <= rem_q - RND_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data_o = lane_q[rd_sel_i];
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Directed bench for mix_round_sequencer: golden phase-schedule model feeds a
// scoreboard queue of expected lanes and done edge, checked when done pulses.
module tb_mix_round_sequencer;

    localparam int FB_REPS  = 12;
    localparam int MUL_REPS = 6;
    localparam int S        = 8 * (5 + FB_REPS + 2 * MUL_REPS);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] rounds;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    mix_round_sequencer #(.FB_REPS(FB_REPS), .MUL_REPS(MUL_REPS), .RND_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds),
        .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .rd_sel_i(rd_sel), .rd_data_o(rd_data), .busy_o(busy), .done_o(done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] lanes;
        logic [31:0]      edge_n;
    } exp_t;

    exp_t        sb_q [$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [8];
    logic [31:0] MA [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    logic [31:0] CA [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
    logic [31:0] MB [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
    logic [31:0] CB [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic mdl_pass(input int ph);
        for (int i = 0; i < 8; i++) begin
            case (ph)
                0: mdl[i] = mdl[i] + 32'(i);
                1: mdl[i] = mdl[i] + mdl[(i + 7) % 8];
                2: mdl[i] = mdl[i] + mdl[(i + 1) % 8] - mdl[(i + 5) % 8];
                3: mdl[i] = mdl[i] ^ (mdl[(i + 3) % 8] << 16);
                4: mdl[i] = mdl[i] - (mdl[(i + 2) % 8] >> 17) + (mdl[(i + 4) % 8] >> 12);
                5: mdl[i] = mdl[i] + mdl[(i + 7) % 8] - mdl[(i + 6) % 8];
                6: mdl[i] = mdl[i] * MA[i] + CA[i];
                default: mdl[i] = mdl[i] * MB[i] + CB[i];
            endcase
        end
    endtask

    task automatic model_rounds(input int n);
        for (int r = 0; r < n; r++) begin
            for (int ph = 0; ph < 5; ph++) mdl_pass(ph);
            for (int f = 0; f < FB_REPS; f++) mdl_pass(5);
            for (int m = 0; m < MUL_REPS; m++) begin
                mdl_pass(6);
                mdl_pass(7);
            end
        end
    endtask

    task automatic push_expect(input int n);
        exp_t e;
        model_rounds(n);
        for (int i = 0; i < 8; i++) e.lanes[i] = mdl[i];
        e.edge_n = 32'(n * S);
        sb_q.push_back(e);
    endtask

    // Called just after an active edge; all reads land before the next falling edge.
    task automatic read_lanes(output logic [7:0][31:0] v);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            v[i] = rd_data;
        end
    endtask

    task automatic kick(input logic [15:0] n);
        @(negedge clk);
        rounds = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic run_to_done(input int from, output int n);
        n = from;
        while (!done && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic sb_check(input string tag, input int n);
        exp_t             e;
        logic [7:0][31:0] v;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_done_edge"}, 32'(n), e.edge_n);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            read_lanes(v);
            for (int i = 0; i < 8; i++) check($sformatf("%s_lane%0d", tag, i), v[i], e.lanes[i]);
            @(posedge clk);
            #1;
            check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0][31:0] v;
        logic [31:0]      chain_exp [8];
        int               n;
        int               done_cnt;
        chain_exp = '{32'd7, 32'd8, 32'd10, 32'd13, 32'd17, 32'd22, 32'd28, 32'd35};
        rst = 1'b1; start = 1'b0; rounds = '0; wr_en = 1'b0;
        wr_sel = '0; wr_data = '0; rd_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        read_lanes(v);
        for (int i = 0; i < 8; i++) check($sformatf("rst_lane%0d", i), v[i], 32'(i));
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Zero all lanes; last write shares its edge with start
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        push_expect(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 3'(i); wr_data = 32'd0;
            if (i == 7) begin
                start = 1'b1; rounds = 16'd1;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        read_lanes(v);
        for (int i = 0; i < 8; i++) check($sformatf("add_lane%0d", i), v[i], 32'(i));
        repeat (8) @(posedge clk);
        #1;
        read_lanes(v);
        for (int i = 0; i < 8; i++) check($sformatf("chain_lane%0d", i), v[i], chain_exp[i]);
        run_to_done(16, n);
        sb_check("r1", n);

        // Three rounds, then one more continuing from that state
        push_expect(3);
        kick(16'd3);
        run_to_done(0, n);
        sb_check("r3", n);
        push_expect(1);
        kick(16'd1);
        run_to_done(0, n);
        sb_check("r3plus1", n);

        // Zero rounds: immediate done, no busy, lanes unchanged
        push_expect(0);
        kick(16'd0);
        check("r0_busy", {31'd0, busy}, 32'd0);
        run_to_done(0, n);
        sb_check("r0", n);

        // Start and write mid-run are ignored
        push_expect(1);
        kick(16'd1);
        repeat (99) @(posedge clk);
        @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_sel = 3'd2; wr_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0; wr_en = 1'b0;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        run_to_done(100, n);
        sb_check("midrun", n);

        // Reset mid-run aborts with no done pulse
        kick(16'd1);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_busy_in_rst", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        read_lanes(v);
        for (int i = 0; i < 8; i++) check($sformatf("abort_lane%0d", i), v[i], 32'(i));
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 300; c++) begin
            if (done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Fresh run from reset values
        for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
        push_expect(1);
        kick(16'd1);
        run_to_done(0, n);
        sb_check("post_rst", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_round_sequencer.md
Name: mix_round_sequencer

Overview:
- Multi-cycle controller for the 8-lane, 32-bit mixing datapath (lanes o0..o7).
- Executes the full mixing round as a fixed phase schedule, one lane update per clock, for a programmable number of rounds.
- Lane updates are strictly in order (lane 0..7), so each update sees already-updated lower lanes.
- Host side uses a start/busy/done handshake plus a lane write/read port.

Parameters:
- FB_REPS, 12, number of feedback passes (phase FB) per round
- MUL_REPS, 6, number of MULA+MULB pass pairs per round
- RND_W, 16, width of the round-count input

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- rounds  in  RND_W  round count, latched on accepted start
- wr_en  in  1  lane write; honoured only in IDLE
- wr_sel  in  3  lane index for write
- wr_data  in  32  write data
- rd_sel  in  3  lane index for read
- rd_data  out  32  combinational view of lane[rd_sel], valid in any state
- busy  out  1  high while RUN
- done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (async): lane[i]=i for i=0..7, FSM=IDLE, busy=0, done=0, counters 0.
- FSM states: IDLE, RUN. No other states.
- IDLE + start=1 at edge: latch rounds. If rounds=0, stay IDLE and pulse done next cycle, lanes unchanged. Otherwise go RUN with phase=ADD, pass=0, lane=0.
- IDLE + start=1 + wr_en=1 on the same edge: write happens first. start is still accepted, and the run uses the written value.
- RUN: every edge performs exactly one lane update, then advances lane index. After lane 7, advance pass/phase.
- Arithmetic for all lane updates:
  - Modulo 2^32, unsigned.
  - Shifts are logical.
  - Indices are mod 8.
  - MA/CA/MB/CB are per-lane constant tables.
- Phase schedule per round, with lane update for index i:
  - ADD: o[i] = o[i] + i
  - CHAIN: o[i] = o[i] + o[i+7]
  - CROSS: o[i] = o[i] + o[i+1] - o[i+5]
  - XSH: o[i] = o[i] ^ (o[i+3] << 16)
  - SHMIX: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12)
  - FB, repeated FB_REPS passes: o[i] = o[i] + o[i+7] - o[i+6]
  - MULA then MULB, pair repeated MUL_REPS times:
    - MULA: o[i] = o[i]*MA[i] + CA[i], with MA = 2,3,5,7,11,13,17,19 and CA = 3,5,7,11,13,17,19,23
    - MULB: o[i] = o[i]*MB[i] + CB[i], with MB = 2,3,3,3,5,13,35,87 and CB = 0,1,8,27,64,125,216,343
  - A phase with a repeat count of 0 is skipped.
- Steps per round: S = 8*(5 + FB_REPS + 2*MUL_REPS); default S = 232.
- Latency: after the start edge, the final update occurs on edge rounds*S. On that same edge FSM goes to IDLE, busy falls and done=1 for exactly one cycle.
- busy=1 from the edge after start through the final update edge.
- start during RUN: ignored, no queuing.
- wr_en during RUN: ignored, and the lane is not corrupted.
- Reset mid-run: immediate abort; lanes return to i; no done pulse.
- Round counter: rounds=2^RND_W-1 must complete without counter wrap.

Test Plan:
- Post-reset read: rd_sel 0..7 -> rd_data = 0..7; busy=0, done=0.
- Write all lanes 0, start with rounds=1:
  - 8 edges after start: lane[i] = i.
  - 16 edges after start: lane[0..7] = 7,8,10,13,17,22,28,35.
- Default params, start with rounds=1 -> done exactly 232 edges after start. Final lanes match a bit-exact C/Python golden model of the phase schedule.
- rounds=3 -> done at edge 696. Lanes match the golden model after 3 rounds. Re-issuing start with rounds=1 continues from that state.
- rounds=0 -> done one cycle later, busy never asserted, lanes unchanged.
- Mid-run (edge 100): assert start and wr_en (lane 2, 0xDEADBEEF) -> both ignored, result identical to an undisturbed run. Then a separate run with rst pulsed at edge 50 -> lanes = 0..7, busy=0, no done.
